// File: rtl/rsp_s2_prep_phase_rotate.sv
// rsp_s2_prep_phase_rotate: rotates four complex lanes per beat by per-lane twiddles
// (out = x * (c + j*s), Q2.30 twiddles, round half-up) through a fixed 4-stage pipeline,
// and tracks frame length against DATA_NUM with a sticky framing-error flag.
// Optional feature macro: RSP_S2_ROT_SAT_EN -- saturate the narrowed result instead of
// wrapping it.
module rsp_s2_prep_phase_rotate #(
  parameter int unsigned DW            = 16,
  parameter int unsigned TWIDDLE_WIDTH = 64,
  parameter int unsigned FRAC          = 30,
  parameter int unsigned DATA_NUM      = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic                          i_data_valid,
  input  logic                          i_data_last,
  input  logic [8*DW-1:0]               i_data,
  input  logic [TWIDDLE_WIDTH-1:0]      i_w [3:0],
  output logic [8*DW-1:0]               o_data,
  output logic                          o_data_valid,
  output logic                          o_data_last,
  output logic                          o_frame_err,
  output logic [$clog2(DATA_NUM/4):0]   o_beat_cnt
);

  localparam int unsigned LAT = 4;
  localparam int unsigned TH  = TWIDDLE_WIDTH / 2;  // width of each of c and s
  localparam int unsigned PW  = DW + TH;            // single product width
  localparam int unsigned SW  = PW + 1;             // sum width, cannot overflow
  localparam int unsigned CW  = $clog2(DATA_NUM / 4) + 1;

  localparam logic [CW-1:0]        LastBeat = CW'(DATA_NUM / 4 - 1);
  localparam logic signed [SW-1:0] RndHalf  = SW'(1) << (FRAC - 1);

`ifdef RSP_S2_ROT_SAT_EN
  localparam logic signed [SW-1:0] SatMax = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SatMin = -SatMax - SW'(1);

  function automatic logic [DW-1:0] sat_narrow(input logic signed [SW-1:0] r);
    if (r > SatMax) begin
      return SatMax[DW-1:0];
    end else if (r < SatMin) begin
      return SatMin[DW-1:0];
    end
    return r[DW-1:0];
  endfunction
`endif

  // Per-lane pipeline registers
  logic signed [DW-1:0] s1_re_q [4];
  logic signed [DW-1:0] s1_im_q [4];
  logic signed [TH-1:0] s1_c_q  [4];
  logic signed [TH-1:0] s1_s_q  [4];
  logic signed [PW-1:0] s2_rc_q [4];
  logic signed [PW-1:0] s2_is_q [4];
  logic signed [PW-1:0] s2_rs_q [4];
  logic signed [PW-1:0] s2_ic_q [4];
  logic signed [SW-1:0] s3_re_q [4];
  logic signed [SW-1:0] s3_im_q [4];
  logic signed [SW-1:0] rnd_re  [4];
  logic signed [SW-1:0] rnd_im  [4];
  logic [8*DW-1:0]      out_d;
  logic [LAT-1:0]       vld_pipe_q;
  logic [LAT-1:0]       lst_pipe_q;
  logic [CW-1:0]        cnt_d;
  logic                 err_d;
`ifndef RSP_S2_ROT_SAT_EN
  logic                 unused_rnd_hi;
`endif

  // Data pipeline S1..S3: capture, multiply, combine; registers run every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        s1_re_q[k] <= '0;
        s1_im_q[k] <= '0;
        s1_c_q[k]  <= '0;
        s1_s_q[k]  <= '0;
        s2_rc_q[k] <= '0;
        s2_is_q[k] <= '0;
        s2_rs_q[k] <= '0;
        s2_ic_q[k] <= '0;
        s3_re_q[k] <= '0;
        s3_im_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        s1_re_q[k] <= i_data[k*2*DW+DW +: DW];
        s1_im_q[k] <= i_data[k*2*DW +: DW];
        s1_c_q[k]  <= i_w[k][TWIDDLE_WIDTH-1 -: TH];
        s1_s_q[k]  <= i_w[k][TH-1:0];
        s2_rc_q[k] <= PW'(s1_re_q[k]) * PW'(s1_c_q[k]);
        s2_is_q[k] <= PW'(s1_im_q[k]) * PW'(s1_s_q[k]);
        s2_rs_q[k] <= PW'(s1_re_q[k]) * PW'(s1_s_q[k]);
        s2_ic_q[k] <= PW'(s1_im_q[k]) * PW'(s1_c_q[k]);
        s3_re_q[k] <= SW'(s2_rc_q[k]) - SW'(s2_is_q[k]);
        s3_im_q[k] <= SW'(s2_rs_q[k]) + SW'(s2_ic_q[k]);
      end
    end
  end

  // S4 combinational part: round half-up, then narrow to DW
  always_comb begin
    out_d = '0;
`ifndef RSP_S2_ROT_SAT_EN
    unused_rnd_hi = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      rnd_re[k] = (s3_re_q[k] + RndHalf) >>> FRAC;
      rnd_im[k] = (s3_im_q[k] + RndHalf) >>> FRAC;
`ifdef RSP_S2_ROT_SAT_EN
      out_d[k*2*DW+DW +: DW] = sat_narrow(rnd_re[k]);
      out_d[k*2*DW +: DW]    = sat_narrow(rnd_im[k]);
`else
      out_d[k*2*DW+DW +: DW] = rnd_re[k][DW-1:0];
      out_d[k*2*DW +: DW]    = rnd_im[k][DW-1:0];
      unused_rnd_hi = unused_rnd_hi ^ (^rnd_re[k][SW-1:DW]) ^ (^rnd_im[k][SW-1:DW]);
`endif
    end
  end

  // S4 output register plus valid/last side-band delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data     <= '0;
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
    end else begin
      o_data     <= out_d;
      vld_pipe_q <= {vld_pipe_q[LAT-2:0], i_data_valid};
      lst_pipe_q <= {lst_pipe_q[LAT-2:0], i_data_last};
    end
  end

  assign o_data_valid = vld_pipe_q[LAT-1];
  assign o_data_last  = lst_pipe_q[LAT-1];

  // Beat counter and framing check; i_start takes priority over any beat that cycle
  always_comb begin
    cnt_d = o_beat_cnt;
    err_d = o_frame_err;
    if (i_start) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (i_data_valid) begin
      if (i_data_last) begin
        cnt_d = '0;
        if (o_beat_cnt != LastBeat) err_d = 1'b1;
      end else if (o_beat_cnt == LastBeat) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = o_beat_cnt + CW'(1);
      end
    end
  end

  // Frame tracking state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_beat_cnt  <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_beat_cnt  <= cnt_d;
      o_frame_err <= err_d;
    end
  end

endmodule
